// File: rtl/ni_read_rqst_gen.sv
// NI remote-read initiator: issues READ flits under a credit limit, forwards READ_RESP data.
// Optional watchdog: define NI_READ_RQST_TIMEOUT_EN.
module ni_read_rqst_gen #(
  parameter int         ROUTER_WIDTH    = 36,
  parameter int         ADDR_WIDTH      = 16,
  parameter int         CNT_WIDTH       = 16,
  parameter int         DST_WIDTH       = 4,
  parameter int         MAX_OUTSTANDING = 8,
  parameter logic [3:0] INFO_READ       = 4'h1,
  parameter logic [3:0] INFO_RESP       = 4'h2,
  parameter int         TIMEOUT_CYCLES  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    rqst_cnt,
  input  logic [DST_WIDTH-1:0]    dst,
  output logic                    out_valid,
  input  logic                    out_rdy,
  output logic [ROUTER_WIDTH-1:0] out_data,
  output logic [DST_WIDTH-1:0]    out_dst,
  input  logic                    in_data_valid,
  input  logic [ROUTER_WIDTH-1:0] in_data,
  output logic                    rd_valid,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [15:0]             rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [7:0] MAX_O = 8'(MAX_OUTSTANDING);
  localparam int         PAD_W = ROUTER_WIDTH - 4 - ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DST_WIDTH-1:0]    dst_q, dst_d;
  logic [CNT_WIDTH-1:0]    iss_q, iss_d;
  logic [CNT_WIDTH-1:0]    ans_q, ans_d;
  logic [7:0]              outst_q, outst_d;
  logic                    err_q, err_d;
  logic                    oval_q, oval_d;
  logic [ROUTER_WIDTH-1:0] odata_q, odata_d;
  logic [DST_WIDTH-1:0]    odst_q, odst_d;
  logic                    rdv_q, rdv_d;
  logic [ADDR_WIDTH-1:0]   rda_q, rda_d;
  logic [15:0]             rdd_q, rdd_d;

  logic is_resp, resp_hit, resp_bad;
  logic xfer, last_xfer, acc_start;
  logic timeout;

  assign is_resp   = in_data_valid &&
                     in_data[ROUTER_WIDTH-1 -: 4] == INFO_RESP;
  assign resp_hit  = is_resp && outst_q != 8'd0;
  assign resp_bad  = is_resp && outst_q == 8'd0;
  assign xfer      = oval_q && out_rdy;
  assign last_xfer = xfer && (iss_q + CNT_WIDTH'(1) == cnt_q);
  assign acc_start = state_q == IDLE && start;

`ifdef NI_READ_RQST_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wdog_q, wdog_d;

  assign wdog_d  = (outst_q == 8'd0 || resp_hit) ? '0
                                                 : wdog_q + 32'd1;
  assign timeout = (state_q == ISSUE || state_q == DRAIN) &&
                   outst_q != 8'd0 && !resp_hit && wdog_q >= TO_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_to;
  assign unused_to = |32'(TIMEOUT_CYCLES);
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      dst_q   <= '0;
      iss_q   <= '0;
      ans_q   <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
      oval_q  <= 1'b0;
      odata_q <= '0;
      odst_q  <= '0;
      rdv_q   <= 1'b0;
      rda_q   <= '0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      iss_q   <= iss_d;
      ans_q   <= ans_d;
      outst_q <= outst_d;
      err_q   <= err_d;
      oval_q  <= oval_d;
      odata_q <= odata_d;
      odst_q  <= odst_d;
      rdv_q   <= rdv_d;
      rda_q   <= rda_d;
      rdd_q   <= rdd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (rqst_cnt == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (timeout)        state_d = DONE;
        else if (last_xfer) state_d = DRAIN;
      end
      DRAIN: begin
        if (timeout || ans_q == cnt_q)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d  = base_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    iss_d   = iss_q;
    ans_d   = ans_q;
    outst_d = outst_q;
    err_d   = err_q;
    if (acc_start) begin
      base_d  = base_addr;
      cnt_d   = rqst_cnt;
      dst_d   = dst;
      iss_d   = '0;
      ans_d   = '0;
      outst_d = '0;
      err_d   = 1'b0;
    end
    if (xfer)     iss_d = iss_q + CNT_WIDTH'(1);
    if (resp_hit) ans_d = ans_q + CNT_WIDTH'(1);
    unique case ({xfer, resp_hit})
      2'b10:   outst_d = outst_q + 8'd1;
      2'b01:   outst_d = outst_q - 8'd1;
      default: ;
    endcase
    if (resp_bad) err_d = 1'b1;
    if (timeout) begin
      err_d   = 1'b1;
      outst_d = '0;
    end
    // Next flit is a function of post-update counters, so stalls hold it
    oval_d  = state_d == ISSUE && iss_d < cnt_d && outst_d < MAX_O;
    odata_d = oval_d ? {INFO_READ, base_d + ADDR_WIDTH'(iss_d),
                        {PAD_W{1'b0}}}
                     : odata_q;
    odst_d  = dst_d;
    rdv_d   = resp_hit;
    rda_d   = resp_hit ? in_data[16 +: ADDR_WIDTH] : rda_q;
    rdd_d   = resp_hit ? in_data[15:0] : rdd_q;
  end

  always_comb begin
    out_valid = oval_q;
    out_data  = odata_q;
    out_dst   = odst_q;
    rd_valid  = rdv_q;
    rd_addr   = rda_q;
    rd_data   = rdd_q;
    err       = err_q;
    busy      = state_q != IDLE;
    done      = state_q == DONE;
  end

endmodule

// File: tb/tb_ni_read_rqst_gen.sv
// Testbench for ni_read_rqst_gen: random ready/response timing
// checked against a transaction-level model of issued/answered requests.
module tb_ni_read_rqst_gen;

  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] rqst_cnt;
  logic [3:0]  dst;
  logic        out_valid;
  logic        out_rdy;
  logic [35:0] out_data;
  logic [3:0]  out_dst;
  logic        in_data_valid;
  logic [35:0] in_data;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  ni_read_rqst_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .rqst_cnt(rqst_cnt), .dst(dst),
    .out_valid(out_valid), .out_rdy(out_rdy),
    .out_data(out_data), .out_dst(out_dst),
    .in_data_valid(in_data_valid), .in_data(in_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: what has been requested / answered in the current command
  logic [15:0] m_base, m_cnt, m_iss, m_ans;
  logic [3:0]  m_dst;
  int          m_outst = 0;
  bit          m_active = 0, m_fin = 0, m_err = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } rsp_t;
  rsp_t rq[$];
  int rd_min = 0, rd_max = 0, hold_until = 0;

  // what was driven into / seen before the coming edge
  bit          p_valid, p_rdy, p_start, p_resp, p_busy;
  logic [35:0] p_data;
  logic [3:0]  p_dst, p_sdst;
  logic [15:0] p_raddr, p_rdata, p_sbase, p_scnt;

  function automatic logic [35:0] flit(logic [15:0] a);
    return {4'h1, a, 16'h0000};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(bit s, logic [15:0] b, logic [15:0] n,
                       logic [3:0] d, bit rdy, bit rsp,
                       logic [15:0] ra, logic [15:0] rdd, bit junk);
    logic [3:0] jinfo;
    jinfo         = 4'($urandom_range(3, 15));
    start         = s;
    base_addr     = b;
    rqst_cnt      = n;
    dst           = d;
    out_rdy       = rdy;
    in_data_valid = rsp | junk;
    in_data       = rsp ? {4'h2, ra, rdd} : {jinfo, ra, rdd};
    p_start = s;  p_sbase = b;  p_scnt = n;  p_sdst = d;
    p_rdy   = rdy;
    p_resp  = rsp;  p_raddr = ra;  p_rdata = rdd;
    p_valid = out_valid;
    p_data  = out_data;
    p_dst   = out_dst;
    p_busy  = busy;
  endtask

  task automatic tick();
    bit dn, ev;
    int ob, due;
    @(posedge clk);
    #1;
    cyc++;
    if (m_fin) begin
      m_active = 0;
      m_fin    = 0;
    end
    ob = m_outst;
    dn = m_active && m_cnt != 0 && m_ans == m_cnt;
    if (p_valid && p_rdy) begin
      chk("xfer_data", p_data, flit(m_base + m_iss));
      chk("xfer_dst", p_dst, m_dst);
      due = cyc + int'($urandom_range(rd_min, rd_max));
      if (due < hold_until) due = hold_until;
      rq.push_back('{due, m_base + m_iss});
      m_iss++;
      m_outst++;
    end
    if (p_resp) begin
      if (ob > 0) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_addr", rd_addr, p_raddr);
        chk("rd_data", rd_data, p_rdata);
        m_ans++;
        m_outst--;
      end else begin
        chk("stray_rd_valid", rd_valid, 0);
        m_err = 1;
      end
    end else begin
      chk("rd_valid_quiet", rd_valid, 0);
    end
    if (p_start && !p_busy) begin
      m_active = 1;
      m_base = p_sbase;  m_cnt = p_scnt;  m_dst = p_sdst;
      m_iss = 0;  m_ans = 0;  m_outst = 0;  m_err = 0;
      if (p_scnt == 0) dn = 1;
    end
    if (dn) m_fin = 1;
    chk("done", done, dn);
    chk("busy", busy, m_active);
    chk("err", err, m_err);
    ev = m_active && !m_fin && m_iss < m_cnt && m_outst < MAXO;
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_data", out_data, flit(m_base + m_iss));
      chk("out_dst", out_dst, m_dst);
    end
  endtask

  task automatic run_case(logic [15:0] b, logic [15:0] n,
                          logic [3:0] d, int mode, int dmin,
                          int dmax, int hold, bit junk_en);
    int k;
    bit r, rs, jk;
    logic [15:0] ra, rdd;
    rd_min = dmin;
    rd_max = dmax;
    hold_until = cyc + hold;
    drive(1, b, n, d, 1, 0, 0, 0, 0);
    tick();
    k = 0;
    while (m_active && k < 3000) begin
      if (mode == 0)      r = 1;
      else if (mode == 1) r = (cyc % 2) == 1;
      else                r = $urandom_range(0, 1) == 1;
      rs  = 0;
      jk  = 0;
      ra  = 16'($urandom);
      rdd = 16'($urandom);
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rs = 1;
        ra = rq[0].addr;
        void'(rq.pop_front());
      end else if (junk_en) begin
        jk = $urandom_range(0, 3) == 0;
      end
      // k==1: a second start while busy must be ignored
      drive(k == 1, ~b, n + 16'd5, ~d, r, rs, ra, rdd, jk);
      tick();
      k++;
    end
    chk("case_complete", m_active, 0);
    chk("queue_empty", rq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dst", out_dst, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    run_case(16'h0010, 16'd4, 4'd3, 0, 2, 2, 0, 0);
    run_case(16'h2000, 16'd20, 4'd7, 0, 1, 1, 15, 0);
    run_case(16'h0400, 16'd4, 4'd1, 1, 1, 3, 0, 0);
    run_case(16'hFFFE, 16'd3, 4'd9, 0, 0, 2, 0, 0);
    run_case(16'h1234, 16'd0, 4'd2, 0, 0, 0, 0, 0);

    // stray response in IDLE
    drive(0, 0, 0, 0, 1, 1, 16'h0ABC, 16'h5555, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 6; i++) begin
      run_case(16'($urandom), 16'($urandom_range(1, 30)),
               4'($urandom), 2, 0, 6, 0, 1);
    end

    // reset mid-operation, then a late response
    rd_min = 0;
    rd_max = 0;
    hold_until = cyc + 1000;
    drive(1, 16'h0100, 16'd10, 4'd5, 1, 0, 0, 0, 0);
    tick();
    repeat (4) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      tick();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    m_active = 0;
    m_fin    = 0;
    m_outst  = 0;
    m_err    = 0;
    rq.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 16'h0101, 16'hBEEF, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();

    run_case(16'h7FF0, 16'd12, 4'd4, 2, 0, 4, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_read_rqst_gen.md
Name: ni_read_rqst_gen

Overview:
Initiator side of the NI remote-read protocol. On a start command it streams READ request flits for a contiguous range of activation addresses into the router, bounded by an outstanding-request credit limit. It also consumes the returning READ_RESP flits, forwards their data to the PE and pulses done once every request has been answered. It sits in the network interface between the PE control logic and the router injection/ejection ports.

Parameters:
ROUTER_WIDTH, 36, flit width; [35:32] info, [31:16] addr, [15:0] data
ADDR_WIDTH, 16, activation address width
CNT_WIDTH, 16, request count width
DST_WIDTH, 4, destination router id width
MAX_OUTSTANDING, 8, maximum in-flight requests (1..255)
INFO_READ, 4'h1, info code of a READ request flit (must match router.vh)
INFO_RESP, 4'h2, info code of a READ_RESP flit (must match router.vh)
TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle start command; accepted only in IDLE
base_addr  in  ADDR_WIDTH  first address requested
rqst_cnt  in  CNT_WIDTH  number of requests to issue
dst  in  DST_WIDTH  destination router id
out_valid  out  1  request flit valid
out_rdy  in  1  router accepts a flit
out_data  out  ROUTER_WIDTH  request flit
out_dst  out  DST_WIDTH  destination of out_data
in_data_valid  in  1  ejected flit valid
in_data  in  ROUTER_WIDTH  ejected flit
rd_valid  out  1  forwarded response valid
rd_addr  out  ADDR_WIDTH  response address (in_data[31:16])
rd_data  out  16  response data (in_data[15:0])
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag; cleared on accepted start

Behaviour:
- Reset values: out_valid=0, out_data=0, out_dst=0, rd_valid=0, rd_addr=0, rd_data=0, done=0, err=0, busy=0. Internal counters are cleared and the FSM returns to IDLE.
- A flit transfers on a cycle where out_valid && out_rdy. While out_valid=1 && out_rdy=0, out_data and out_dst are held stable.
- Request flit format: info=INFO_READ, addr=base_addr+issued_cnt (wraps modulo 2^ADDR_WIDTH), data=0.
- FSM states and transitions:
  IDLE: on start, latch base_addr/rqst_cnt/dst, clear issued/answered/outstanding and err, go to ISSUE. If rqst_cnt==0, go directly to DONE instead.
  ISSUE: out_valid is registered. A flit is presented when issued_cnt<rqst_cnt and outstanding<MAX_OUTSTANDING. On each transfer, issued_cnt++ and outstanding++. When the last flit transfers, go to DRAIN.
  DRAIN: wait until answered_cnt==rqst_cnt, then go to DONE.
  DONE: done=1 for exactly one cycle, then return to IDLE.
- First request flit becomes valid the cycle after start (1-cycle latency). With out_rdy held high and credit available, throughput is 1 flit/cycle.
- Response path: in_data_valid && in_data[35:32]==INFO_RESP while outstanding>0 registers rd_valid/rd_addr/rd_data on the next edge and does outstanding--, answered_cnt++.
- Flits with any other info code are ignored.
- A response arriving while outstanding==0, including in IDLE, is not forwarded and sets err.
- Transfer and response in the same cycle leave outstanding unchanged; both counts still advance.
- start while busy=1 is ignored.
- At outstanding==MAX_OUTSTANDING, out_valid drops after the current transfer and rises again the cycle after a response is received.
- rst asserted mid-operation aborts immediately: no done, in-flight responses arriving afterwards set err.

Optional Feature:
NI_READ_RQST_TIMEOUT_EN: when defined, a watchdog counter runs while outstanding>0 and is reset on every accepted response. Reaching TIMEOUT_CYCLES sets err, drops out_valid and forces DONE (done pulses). When undefined, no watchdog exists and the block waits indefinitely.

Test Plan:
- base_addr=0x0010, rqst_cnt=4, dst=3, out_rdy=1, responses 2 cycles after each request -> flits 0x1_0010_0000..0x1_0013_0000 on consecutive cycles, out_dst=3, four rd_valid pulses, single done, err=0.
- rqst_cnt=20, MAX_OUTSTANDING=8, no responses -> exactly 8 flits, then out_valid=0; one response -> a 9th flit follows next cycle.
- out_rdy toggled 0/1 each cycle -> out_data stable while stalled, 4 transfers total, no duplicated or skipped address.
- base_addr=0xFFFE, rqst_cnt=3 -> addrs 0xFFFE, 0xFFFF, 0x0000.
- rqst_cnt=0 -> done the cycle after start, no flits; stray INFO_RESP flit in IDLE -> err=1, no rd_valid.
- With NI_READ_RQST_TIMEOUT_EN and TIMEOUT_CYCLES=16, rqst_cnt=2, one response only -> err=1 and done 16 cycles after the last response.
